json_uart_rx: RTL and testbench
===============================

// Module: json_uart_rx
// PURPOSE
// Receive end of the JSON motor-command UART link. Deserialises 8N1 bytes from a GPIO pin and parses
// frames {"T":<int>,"L":<dec>,"R":<dec>}\n. Outputs signed milli-unit wheel speeds plus a one-cycle commit
// strobe. Sits at the rover/bench side, opposite the JSON command transmitter.
// PARAMETERS
// CLKS_PER_BIT   434         clk cycles per UART bit (115200 baud @ 50 MHz)
// TIMEOUT_CLKS   5_000_000   idle clks mid-frame before abort (100 ms)
// MAX_LEN        64          max bytes per frame incl. '{' and '\n'
// PORTS
// clk          in   1   system clock
// rst          in   1   asynchronous, active-low reset (0 = reset)
// uart_in      in   1   serial RX line, idle high, asynchronous to clk
// cmd_t        out  8   last committed T value, integer, saturates at 255
// cmd_left     out  16  last committed L, signed, value*1000, saturated to +/-32767
// cmd_right    out  16  last committed R, same format as cmd_left
// fields_seen  out  3   {T,L,R} keys present in last committed frame
// cmd_valid    out  1   1-cycle pulse: outputs just updated
// parse_error  out  1   1-cycle pulse: frame rejected
// busy         out  1   high while a frame is in progress (state != IDLE)
// frame_count  out  8   committed-frame counter, wraps 255->0
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, accumulators and timeout cleared. Reset mid-frame discards the frame.
// - uart_rx: 2-FF sync; start bit qualified at half-bit; data sampled mid-bit LSB first.
//   Checks stop bit and emits rx_data/rx_valid (1 cycle) and rx_ferr.
// - FSM (advances only on rx_valid): IDLE -'{'-> KEY_Q -'"'-> KEY -T|L|R-> KEY_END -'"'-> COLON -':'-> VAL_SIGN;
//   VAL_SIGN: '-' sets neg, digit -> VAL_INT; VAL_INT digit / '.'->VAL_FRAC; VAL_INT|VAL_FRAC: ','->KEY_Q,
//   '}'->EXPECT_NL; EXPECT_NL '\n' -> commit, IDLE. ERR_SKIP: drop bytes until '\n', then IDLE.
// - IDLE ignores all bytes except '{'. Space (0x20) ignored in every state except KEY.
// - Any unexpected byte, unknown key, rx_ferr, or byte count > MAX_LEN: parse_error pulse, go to ERR_SKIP.
// - '{' in any non-IDLE state: parse_error pulse, restart as new frame (count = 1, state KEY_Q).
// - Value arithmetic: int_acc = min(int_acc*10+d, 999). Up to 3 frac digits weigh 100/10/1; extra digits ignored.
//   mag = int_acc*1000 + frac, 20-bit, saturated to 32767; result = neg ? -mag : mag.
//   T uses min(int_acc,255); neg/frac on T is a parse error.
// - Values are staged in shadow regs; live outputs change only at commit. Duplicate key: last value wins.
//   A missing key keeps its previous output and clears its fields_seen bit.
// - Commit: cmd_* and fields_seen load, and cmd_valid pulses, on the cycle after the '\n' rx_valid
//   (latency 1). frame_count increments on that same edge.
// - Empty frame "{}\n": parse error (at least one key required).
// - Timeout: counter reloads on every rx_valid and counts only when state != IDLE.
//   Reaching 0 -> parse_error, IDLE. If a byte arrives in the same cycle as expiry, the byte wins.
// - cmd_valid and parse_error are never both high in the same cycle.
// STRUCTURE
// - Package json_rx_pkg: ASCII constants (LBRACE, RBRACE, QUOTE, COLON, COMMA, MINUS, DOT, NL, SPACE),
//   parser state enum, MILLI_MAX=32767, field index enum {F_T, F_L, F_R}.
// - Sub-module uart_rx (CLKS_PER_BIT): sync, bit timing, shift reg, stop check; out rx_data/rx_valid/rx_ferr.
// - Top: parser FSM, value accumulators, shadow/commit regs, timeout and length counters.
// TESTING (bench drives uart_in at CLKS_PER_BIT; rst toggled low 5 clks at start)
// 1. {"T":1,"L":0.5,"R":0.5}\n -> cmd_t=1, left=500, right=500, fields=111, one cmd_valid, frame_count=1
// 2. {"T":1,"L":-0.10,"R":0.10}\n then {"T":1,"L":0,"R":0}\n -> (-100,100) commit, then (0,0), count=3
// 3. {"T":1,"X":3}\n -> parse_error once, no cmd_valid, outputs unchanged; next good frame commits
// 4. {"L":99.9999}\n -> left=32767, right and T unchanged, fields=010
// 5. {"T":1,"L":0. then silence > TIMEOUT_CLKS -> parse_error, busy=0; "{" mid-frame -> error + resync
// 6. rst=0 during byte 10 of case 1 -> all outputs 0 immediately; replayed frame commits correctly

Source files
------------

// File: rtl/json_rx_pkg.sv
// Shared constants, parser state and field encodings for the JSON motor-command receiver.
// Pure definitions; no latency or flow control.
package json_rx_pkg;

    localparam logic [7:0] LBRACE = 8'h7B;
    localparam logic [7:0] RBRACE = 8'h7D;
    localparam logic [7:0] QUOTE  = 8'h22;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] MINUS  = 8'h2D;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] NL     = 8'h0A;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] CH_T   = 8'h54;
    localparam logic [7:0] CH_L   = 8'h4C;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;

    localparam logic [15:0] MILLI_MAX = 16'd32767;

    typedef enum logic [3:0] {
        ST_IDLE, ST_KEY_Q, ST_KEY, ST_KEY_END, ST_COLON,
        ST_VAL_SIGN, ST_VAL_INT, ST_VAL_FRAC, ST_EXPECT_NL, ST_ERR_SKIP
    } pstate_e;

    // Encoded as the bit position inside fields_seen = {T,L,R}.
    typedef enum logic [1:0] {
        F_R = 2'd0,
        F_L = 2'd1,
        F_T = 2'd2
    } field_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    function automatic logic [15:0] to_milli(input logic [9:0] int_part,
                                             input logic [9:0] frac_part,
                                             input logic       neg);
        logic [19:0] mag;
        logic [15:0] sat;
        mag = 20'(int_part) * 20'd1000 + 20'(frac_part);
        sat = (mag > 20'(MILLI_MAX)) ? MILLI_MAX : mag[15:0];
        return neg ? (16'd0 - sat) : sat;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser: 2-FF sync, half-bit start qualification, mid-bit sampling, stop check.
// rx_valid pulses one cycle after the mid-stop sample; no backpressure, bytes are never held.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    ust_q, ust_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic          rx;

    assign rx = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], rx_in};
        ust_d  = ust_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        sr_d   = sr_q;
        data_d = data_q;
        vld_d  = 1'b0;
        ferr_d = 1'b0;
        case (ust_q)
            U_IDLE: begin
                if (!rx) begin
                    ust_d = U_START;
                    cnt_d = '0;
                end
            end
            U_START: begin
                // A low that does not survive to mid-bit is a glitch, not a start bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    ust_d = rx ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sr_d  = {rx, sr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        ust_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    vld_d  = 1'b1;
                    ferr_d = !rx;
                    data_d = sr_q;
                    ust_d  = U_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            ust_q  <= U_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sr_q   <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            ust_q  <= ust_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sr_q   <= sr_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            ferr_q <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = vld_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/json_uart_rx.sv
// Parses {"T":<int>,"L":<dec>,"R":<dec>}\n frames from a UART into milli-unit wheel commands.
// Commit/error strobes one cycle after the deciding byte; no backpressure, the line cannot be stalled.
module json_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5_000_000,
    parameter int MAX_LEN      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic [7:0]  cmd_t,
    output logic [15:0] cmd_left,
    output logic [15:0] cmd_right,
    output logic [2:0]  fields_seen,
    output logic        cmd_valid,
    output logic        parse_error,
    output logic        busy,
    output logic [7:0]  frame_count
);

    import json_rx_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (uart_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    pstate_e       state_q, state_d;
    field_e        key_q, key_d;
    logic          neg_q, neg_d;
    logic [9:0]    int_acc_q, int_acc_d;
    logic [9:0]    frac_q, frac_d;
    logic [1:0]    frac_cnt_q, frac_cnt_d;
    logic [7:0]    sh_t_q, sh_t_d;
    logic [15:0]   sh_l_q, sh_l_d;
    logic [15:0]   sh_r_q, sh_r_d;
    logic [2:0]    seen_q, seen_d;
    logic [LW-1:0] len_q, len_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [7:0]    cmd_t_q, cmd_t_d;
    logic [15:0]   cmd_l_q, cmd_l_d;
    logic [15:0]   cmd_r_q, cmd_r_d;
    logic [2:0]    fields_q, fields_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          parse_error_q, parse_error_d;
    logic [7:0]    fcount_q, fcount_d;

    logic          err, fail, restart, store, commit;
    logic [3:0]    digit;
    logic [13:0]   int_next;
    logic [9:0]    int_sat;
    logic [9:0]    frac_add;
    logic [7:0]    t_val;
    logic [15:0]   milli_val;

    assign digit     = rx_data[3:0];
    assign int_next  = 14'(int_acc_q) * 14'd10 + 14'(digit);
    assign int_sat   = (int_next > 14'd999) ? 10'd999 : int_next[9:0];
    assign t_val     = (int_acc_q > 10'd255) ? 8'd255 : int_acc_q[7:0];
    assign milli_val = to_milli(int_acc_q, frac_q, neg_q);

    always_comb begin
        case (frac_cnt_q)
            2'd0:    frac_add = 10'(digit) * 10'd100;
            2'd1:    frac_add = 10'(digit) * 10'd10;
            default: frac_add = 10'(digit);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        neg_d      = neg_q;
        int_acc_d  = int_acc_q;
        frac_d     = frac_q;
        frac_cnt_d = frac_cnt_q;
        sh_t_d     = sh_t_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        seen_d     = seen_q;
        len_d      = len_q;
        tmo_d      = tmo_q;
        err        = 1'b0;
        fail       = 1'b0;
        restart    = 1'b0;
        store      = 1'b0;
        commit     = 1'b0;

        if (rx_valid) begin
            tmo_d = TMO_LOAD;
            case (state_q)
                ST_IDLE: restart = !rx_ferr && (rx_data == LBRACE);
                ST_ERR_SKIP: begin
                    if (!rx_ferr) begin
                        if (rx_data == LBRACE) begin
                            err     = 1'b1;
                            restart = 1'b1;
                        end else if (rx_data == NL) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (rx_ferr) begin
                        fail = 1'b1;
                    end else if (rx_data == LBRACE) begin
                        err     = 1'b1;
                        restart = 1'b1;
                    end else if (len_q >= LEN_MAX) begin
                        fail = 1'b1;
                    end else begin
                        len_d = len_q + LW'(1);
                        // Spaces are only significant inside a key name.
                        if (rx_data != SPACE || state_q == ST_KEY) begin
                            case (state_q)
                                ST_KEY_Q: begin
                                    if (rx_data == QUOTE) state_d = ST_KEY;
                                    else                  fail = 1'b1;
                                end
                                ST_KEY: begin
                                    state_d = ST_KEY_END;
                                    if (rx_data == CH_T)      key_d = F_T;
                                    else if (rx_data == CH_L) key_d = F_L;
                                    else if (rx_data == CH_R) key_d = F_R;
                                    else                      fail = 1'b1;
                                end
                                ST_KEY_END: begin
                                    if (rx_data == QUOTE) state_d = ST_COLON;
                                    else                  fail = 1'b1;
                                end
                                ST_COLON: begin
                                    if (rx_data == COLON) begin
                                        state_d    = ST_VAL_SIGN;
                                        neg_d      = 1'b0;
                                        int_acc_d  = '0;
                                        frac_d     = '0;
                                        frac_cnt_d = '0;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                                ST_VAL_SIGN: begin
                                    if (is_digit(rx_data)) begin
                                        int_acc_d = 10'(digit);
                                        state_d   = ST_VAL_INT;
                                    end else if (rx_data == MINUS && !neg_q && key_q != F_T) begin
                                        neg_d = 1'b1;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                                ST_VAL_INT, ST_VAL_FRAC: begin
                                    if (is_digit(rx_data)) begin
                                        if (state_q == ST_VAL_INT) begin
                                            int_acc_d = int_sat;
                                        end else if (frac_cnt_q != 2'd3) begin
                                            frac_d     = frac_q + frac_add;
                                            frac_cnt_d = frac_cnt_q + 2'd1;
                                        end
                                    end else if (rx_data == DOT && state_q == ST_VAL_INT && key_q != F_T) begin
                                        state_d = ST_VAL_FRAC;
                                    end else if (rx_data == COMMA) begin
                                        store   = 1'b1;
                                        state_d = ST_KEY_Q;
                                    end else if (rx_data == RBRACE) begin
                                        store   = 1'b1;
                                        state_d = ST_EXPECT_NL;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                                ST_EXPECT_NL: begin
                                    if (rx_data == NL) begin
                                        commit  = 1'b1;
                                        state_d = ST_IDLE;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                                default: fail = 1'b1;
                            endcase
                        end
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q <= TW'(1)) begin
                err     = 1'b1;
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end

        if (restart) begin
            state_d = ST_KEY_Q;
            len_d   = LW'(1);
            seen_d  = '0;
        end
        if (fail) begin
            err     = 1'b1;
            state_d = ST_ERR_SKIP;
        end
        if (store) begin
            case (key_q)
                F_T: begin
                    sh_t_d    = t_val;
                    seen_d[2] = 1'b1;
                end
                F_L: begin
                    sh_l_d    = milli_val;
                    seen_d[1] = 1'b1;
                end
                F_R: begin
                    sh_r_d    = milli_val;
                    seen_d[0] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Live outputs move only at commit; absent keys keep their last committed value.
    always_comb begin
        cmd_t_d       = cmd_t_q;
        cmd_l_d       = cmd_l_q;
        cmd_r_d       = cmd_r_q;
        fields_d      = fields_q;
        fcount_d      = fcount_q;
        cmd_valid_d   = commit;
        parse_error_d = err;
        if (commit) begin
            if (seen_q[2]) cmd_t_d = sh_t_q;
            if (seen_q[1]) cmd_l_d = sh_l_q;
            if (seen_q[0]) cmd_r_d = sh_r_q;
            fields_d = seen_q;
            fcount_d = fcount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_q         <= F_T;
            neg_q         <= 1'b0;
            int_acc_q     <= '0;
            frac_q        <= '0;
            frac_cnt_q    <= '0;
            sh_t_q        <= '0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
            seen_q        <= '0;
            len_q         <= '0;
            tmo_q         <= '0;
            cmd_t_q       <= '0;
            cmd_l_q       <= '0;
            cmd_r_q       <= '0;
            fields_q      <= '0;
            cmd_valid_q   <= 1'b0;
            parse_error_q <= 1'b0;
            fcount_q      <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            neg_q         <= neg_d;
            int_acc_q     <= int_acc_d;
            frac_q        <= frac_d;
            frac_cnt_q    <= frac_cnt_d;
            sh_t_q        <= sh_t_d;
            sh_l_q        <= sh_l_d;
            sh_r_q        <= sh_r_d;
            seen_q        <= seen_d;
            len_q         <= len_d;
            tmo_q         <= tmo_d;
            cmd_t_q       <= cmd_t_d;
            cmd_l_q       <= cmd_l_d;
            cmd_r_q       <= cmd_r_d;
            fields_q      <= fields_d;
            cmd_valid_q   <= cmd_valid_d;
            parse_error_q <= parse_error_d;
            fcount_q      <= fcount_d;
        end
    end

    assign cmd_t       = cmd_t_q;
    assign cmd_left    = cmd_l_q;
    assign cmd_right   = cmd_r_q;
    assign fields_seen = fields_q;
    assign cmd_valid   = cmd_valid_q;
    assign parse_error = parse_error_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_json_uart_rx.sv
// Scoreboard bench for json_uart_rx: directed frames over the serial line, expected strobes queued per frame.
module tb_json_uart_rx;

    localparam int CPB  = 8;
    localparam int TMO  = 3000;
    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_in = 1'b1;
    logic [7:0]  cmd_t;
    logic [15:0] cmd_left;
    logic [15:0] cmd_right;
    logic [2:0]  fields_seen;
    logic        cmd_valid;
    logic        parse_error;
    logic        busy;
    logic [7:0]  frame_count;

    json_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO),
        .MAX_LEN      (MAXL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .cmd_t       (cmd_t),
        .cmd_left    (cmd_left),
        .cmd_right   (cmd_right),
        .fields_seen (fields_seen),
        .cmd_valid   (cmd_valid),
        .parse_error (parse_error),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [7:0]  t;
        logic [15:0] l;
        logic [15:0] r;
        logic [2:0]  f;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_e;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  m_t   = 8'd0;
    logic [15:0] m_l   = 16'd0;
    logic [15:0] m_r   = 16'd0;
    logic [2:0]  m_f   = 3'd0;
    logic [7:0]  m_cnt = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_commit(input logic [7:0] t, input logic [15:0] l, input logic [15:0] r,
                              input logic [2:0] f, input logic [7:0] cnt);
        ev_t e;
        m_t = t; m_l = l; m_r = r; m_f = f; m_cnt = cnt;
        e.err = 1'b0; e.t = t; e.l = l; e.r = r; e.f = f; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e.err = 1'b1; e.t = m_t; e.l = m_l; e.r = m_r; e.f = m_f; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_in = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (4) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && (cmd_valid || parse_error)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: cmd_valid=%0b parse_error=%0b, expected no strobe (t=%0t)",
                         cmd_valid, parse_error, $time);
            end else begin
                mon_e = sb.pop_front();
                check("evt_cmd_valid",   32'(cmd_valid),   32'(!mon_e.err));
                check("evt_parse_error", 32'(parse_error), 32'(mon_e.err));
                check("evt_cmd_t",       32'(cmd_t),       32'(mon_e.t));
                check("evt_cmd_left",    32'(cmd_left),    32'(mon_e.l));
                check("evt_cmd_right",   32'(cmd_right),   32'(mon_e.r));
                check("evt_fields_seen", 32'(fields_seen), 32'(mon_e.f));
                check("evt_frame_count", 32'(frame_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: simulation exceeded 90000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string sp;
        rst     = 1'b0;
        uart_in = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_t",       32'(cmd_t),       32'd0);
        check("rst_cmd_left",    32'(cmd_left),    32'd0);
        check("rst_cmd_right",   32'(cmd_right),   32'd0);
        check("rst_fields_seen", 32'(fields_seen), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_cmd_valid",   32'(cmd_valid),   32'd0);
        check("rst_parse_error", 32'(parse_error), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        exp_commit(8'd1, 16'd500, 16'd500, 3'b111, 8'd1);
        send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
        wait_drain(200);
        check("idle_after_commit_busy", 32'(busy), 32'd0);

        exp_commit(8'd1, 16'hFF9C, 16'd100, 3'b111, 8'd2);
        send_str("{\"T\":1,\"L\":-0.10,\"R\":0.10}\n");
        wait_drain(200);
        exp_commit(8'd1, 16'd0, 16'd0, 3'b111, 8'd3);
        send_str("{\"T\":1,\"L\":0,\"R\":0}\n");
        wait_drain(200);

        exp_err();
        send_str("{\"T\":1,\"X\":3}\n");
        wait_drain(200);
        exp_commit(8'd7, 16'd1250, 16'hF830, 3'b111, 8'd4);
        send_str("{\"T\":7,\"L\":1.25,\"R\":-2}\n");
        wait_drain(200);

        exp_commit(8'd7, 16'd32767, 16'hF830, 3'b010, 8'd5);
        send_str("{\"L\":99.9999}\n");
        wait_drain(200);

        exp_commit(8'd255, 16'd32767, 16'h8001, 3'b101, 8'd6);
        send_str("{ \"T\" : 300 , \"R\":-40 }\n");
        wait_drain(200);

        exp_err();
        send_str("{\"T\":1,\"L\":0.");
        check("midframe_busy", 32'(busy), 32'd1);
        wait_drain(TMO + 200);
        check("timeout_busy", 32'(busy), 32'd0);

        exp_err();
        exp_commit(8'd4, 16'd32767, 16'd1000, 3'b101, 8'd7);
        send_str("{\"T\":3,\"L{\"T\":4,\"R\":1}\n");
        wait_drain(200);

        exp_err();
        send_str("{}\n");
        wait_drain(200);

        sp = "";
        for (int i = 0; i < 70; i++) sp = {sp, " "};
        exp_err();
        send_str({"{\"T\":5", sp, "}\n"});
        wait_drain(200);
        check("overlength_busy", 32'(busy), 32'd0);

        send_str("{\"T\":1,\"L");
        uart_in = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        check("prereset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_cmd_t",       32'(cmd_t),       32'd0);
        check("midrst_cmd_left",    32'(cmd_left),    32'd0);
        check("midrst_cmd_right",   32'(cmd_right),   32'd0);
        check("midrst_fields_seen", 32'(fields_seen), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_busy",        32'(busy),        32'd0);
        uart_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        m_t = 8'd0; m_l = 16'd0; m_r = 16'd0; m_f = 3'd0; m_cnt = 8'd0;
        repeat (4 * CPB) @(posedge clk);

        exp_commit(8'd1, 16'd500, 16'd500, 3'b111, 8'd1);
        send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
        wait_drain(200);
        repeat (50) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
